// File: rtl/if_id_stage_pkg.sv
// if_id_stage_pkg: shared fetch/decode pipeline constants and FSM state type
package if_id_stage_pkg;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef enum logic [1:0] {RUN, STALL, STUCK} wd_state_e;
endpackage

// File: rtl/if_id_stage_sat_counter.sv
// sat_counter: counter that increments on inc and sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  // count up until every bit is set, then hold
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (inc && count != '1) count <= count + CNT_W'(1);
endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: PC and IF/ID register with flush/hold priority, perf counters and stall watchdog
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC),
  parameter int          CNT_W     = 16,
  parameter int          MAX_STALL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_write,
  input  logic             awrite,
  input  logic             flush,
  input  logic [WIDTH-1:0] pc_next,
  input  logic [WIDTH-1:0] instr_in,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] if_id_instr,
  output logic [WIDTH-1:0] if_id_pc4,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             stall_err,
  output logic             mismatch_err
);
  wd_state_e  state, state_n;
  logic [3:0] run_len, run_n, run_inc;
  logic       stall;
  assign stall    = !awrite && !flush;
  assign pc_plus4 = pc + WIDTH'(4);
  assign run_inc  = run_len + 4'd1;
  assign stall_err = state == STUCK;
  // PC holds unless pc_write; a flush target arrives through pc_next
  always_ff @(posedge clk)
    if (rst) pc <= RESET_PC;
    else if (pc_write) pc <= pc_next;
  // IF/ID: flush squashes to a NOP, otherwise awrite low holds the slot
  always_ff @(posedge clk)
    if (rst || flush) begin
      if_id_instr <= WIDTH'(NOP);
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
    end else if (awrite) begin
      if_id_instr <= instr_in;
      if_id_pc4   <= pc_plus4;
      if_id_valid <= 1'b1;
    end
  // sticky flag for pc_write and awrite disagreeing
  always_ff @(posedge clk)
    if (rst) mismatch_err <= 1'b0;
    else if (pc_write != awrite) mismatch_err <= 1'b1;
  // watchdog state and consecutive-stall run length
  always_ff @(posedge clk)
    if (rst) begin
      state   <= RUN;
      run_len <= '0;
    end else begin
      state   <= state_n;
      run_len <= run_n;
    end
  // run length is 0 in RUN, so run_inc gives 1 on entry to STALL; STUCK absorbs
  always_comb begin
    state_n = state;
    run_n   = run_len;
    if (state != STUCK) begin
      run_n   = stall ? run_inc : 4'd0;
      state_n = !stall ? RUN : (run_inc == 4'(MAX_STALL)) ? STUCK : STALL;
    end
  end
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (.clk(clk), .rst(rst), .inc(stall), .count(stall_count));
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (.clk(clk), .rst(rst), .inc(flush), .count(flush_count));
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: randomized scoreboard bench for if_id_stage against a behavioural model
module tb_if_id_stage;
  localparam int MAXS = 4;
  logic        clk = 0, rst = 1, pc_write = 0, awrite = 0, flush = 0;
  logic [31:0] pc_next = 0, instr_in = 0;
  logic [31:0] pc, pc_plus4, if_id_instr, if_id_pc4;
  logic        if_id_valid, stall_err, mismatch_err;
  logic [3:0]  stall_count, flush_count;
  typedef struct {
    logic [31:0] pc, pcp4, instr, pc4;
    logic        valid, serr, merr;
    logic [3:0]  sc, fc;
  } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_stuck, m_mis;
  int          m_sc, m_fc, m_run;
  if_id_stage #(.WIDTH(32), .RESET_PC(32'h0), .CNT_W(4), .MAX_STALL(MAXS)) dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .awrite(awrite), .flush(flush),
    .pc_next(pc_next), .instr_in(instr_in), .pc(pc), .pc_plus4(pc_plus4),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
    .stall_count(stall_count), .flush_count(flush_count),
    .stall_err(stall_err), .mismatch_err(mismatch_err));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask
  // monitor: every cycle that has an expectation queued, compare the DUT outputs
  initial forever begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc", pc, e.pc);
      chk("pc_plus4", pc_plus4, e.pcp4);
      chk("if_id_instr", if_id_instr, e.instr);
      chk("if_id_pc4", if_id_pc4, e.pc4);
      chk("if_id_valid", 32'(if_id_valid), 32'(e.valid));
      chk("stall_count", 32'(stall_count), 32'(e.sc));
      chk("flush_count", 32'(flush_count), 32'(e.fc));
      chk("stall_err", 32'(stall_err), 32'(e.serr));
      chk("mismatch_err", 32'(mismatch_err), 32'(e.merr));
    end
  end
  // drive one cycle of inputs, advance the model, queue what the DUT must show after the edge
  task automatic step(input logic r, input logic pw, input logic aw, input logic fl,
                      input logic [31:0] pn, input logic [31:0] ins);
    exp_t e;
    @(negedge clk);
    rst = r; pc_write = pw; awrite = aw; flush = fl; pc_next = pn; instr_in = ins;
    if (r) begin
      m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0;
      m_sc = 0; m_fc = 0; m_run = 0; m_stuck = 0; m_mis = 0;
    end else begin
      if (fl) begin m_instr = 0; m_pc4 = 0; m_valid = 0; end
      else if (aw) begin m_instr = ins; m_pc4 = m_pc + 32'd4; m_valid = 1; end
      if (pw) m_pc = pn;
      if (!aw && !fl) m_sc = (m_sc == 15) ? 15 : m_sc + 1;
      if (fl) m_fc = (m_fc == 15) ? 15 : m_fc + 1;
      m_run = (!aw && !fl) ? m_run + 1 : 0;
      if (m_run >= MAXS) m_stuck = 1;
      if (pw != aw) m_mis = 1;
    end
    e.pc = m_pc; e.pcp4 = m_pc + 32'd4; e.instr = m_instr; e.pc4 = m_pc4;
    e.valid = m_valid; e.sc = 4'(m_sc); e.fc = 4'(m_fc); e.serr = m_stuck; e.merr = m_mis;
    q.push_back(e);
  endtask
  function automatic logic [31:0] ins_of(input logic [31:0] p);
    return p ^ 32'hA5A5_0013;
  endfunction
  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 1, 0, m_pc + 32'd4, ins_of(m_pc));
  endtask
  initial begin
    step(1, 1, 1, 1, 32'h1234, 32'hDEAD);
    step(1, 0, 0, 0, 32'h5678, 32'hBEEF);
    run(2);
    step(0, 0, 0, 0, 32'h99, ins_of(m_pc));
    run(3);
    step(0, 1, 0, 1, 32'h40, 32'h777);
    run(2);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 32'h0, 32'h1);
    run(3);
    step(1, 0, 0, 0, 0, 0);
    run(1);
    step(0, 1, 0, 0, m_pc + 32'd4, 32'h55);
    for (int i = 0; i < 20; i++) step(0, 1, 1, 1, 32'h100 + 32'(i), 32'h9);
    step(0, 1, 1, 0, 32'hFFFF_FFFC, 32'h3);
    run(2);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    run(2);
    for (int i = 0; i < 400; i++) begin
      logic r, pw, aw, fl;
      logic [31:0] pn;
      r  = ($urandom_range(0, 59) == 0);
      aw = ($urandom_range(0, 3) != 0);
      pw = ($urandom_range(0, 29) == 0) ? !aw : aw;
      fl = ($urandom_range(0, 7) == 0);
      pn = ($urandom_range(0, 3) == 0) ? $urandom : m_pc + 32'd4;
      step(r, pw, aw, fl, pn, $urandom);
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain got=%0d pending want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
Fetch-side consumer of the load-use stall signals (pc_write, awrite) and of the branch/jump flush. Holds the PC register and the IF/ID pipeline register, and applies hold/flush with fixed priority. Keeps saturating stall and flush performance counters. Runs a small FSM that flags a stall that never releases (protocol/deadlock watchdog) and a pc_write/awrite disagreement.

Parameters:
WIDTH, 32, datapath width of PC and instruction
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 16, width of each performance counter
MAX_STALL, 4, consecutive stall cycles that trip stall_err (legal range 2..15)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
pc_write  input  1  1 = PC loads pc_next; 0 = PC holds
awrite  input  1  1 = IF/ID loads; 0 = IF/ID holds (stall)
flush  input  1  taken branch/jump in ID; squash IF/ID
pc_next  input  WIDTH  next PC from external PC mux
instr_in  input  WIDTH  instruction fetched at pc
pc  output  WIDTH  current PC register
pc_plus4  output  WIDTH  pc + 4, combinational, modulo 2^WIDTH
if_id_instr  output  WIDTH  registered instruction to ID
if_id_pc4  output  WIDTH  registered pc+4 to ID
if_id_valid  output  1  1 = if_id_instr is a real instruction
stall_count  output  CNT_W  saturating count of stall cycles
flush_count  output  CNT_W  saturating count of flush cycles
stall_err  output  1  sticky: stall held for MAX_STALL consecutive cycles
mismatch_err  output  1  sticky: pc_write != awrite observed

Behaviour:
- Reset (rst=1 at edge), regardless of other inputs:
  - pc=RESET_PC; if_id_instr=0 (NOP); if_id_pc4=0; if_id_valid=0.
  - Both counters 0; both error flags 0; FSM=RUN; run length 0.
- PC register: on edge, if pc_write then pc<=pc_next, else hold. flush does not affect PC; the external mux already supplies the target on pc_next.
- IF/ID register, priority flush > hold > load:
  - flush=1: instr<=0, pc4<=0, valid<=0. Applies even when awrite=0.
  - Else awrite=0: all three hold.
  - Else: instr<=instr_in, pc4<=pc_plus4, valid<=1.
- Latency: instr_in to if_id_instr is 1 cycle; no combinational path from inputs to registered outputs.
- Stall event (per cycle) = awrite==0 && flush==0.
- stall_count increments on each stall event; flush_count increments on each cycle with flush=1. Both saturate at all-ones and never wrap.
- FSM states RUN, STALL, STUCK; run length is a 4-bit counter.
  - RUN: on stall event -> STALL, run length=1; otherwise stay, run length=0.
  - STALL: stall event -> run length+1. If the new value == MAX_STALL -> STUCK and set stall_err. No stall event -> RUN, run length=0.
  - STUCK: absorbing until rst; stall_err stays 1; datapath keeps operating normally.
- mismatch_err: set on any non-reset cycle with pc_write != awrite; sticky until rst.
- Simultaneous flush and awrite=0: flush wins, counts as a flush (not a stall), and the FSM treats it as a non-stall cycle.
- pc_plus4 wrap: 32'hFFFF_FFFC gives 32'h0000_0000.
- rst asserted mid-stall or in STUCK: the next edge restores all reset values.

Decomposition:
- Shared pipeline package holds:
  - NOP instruction constant (32'h0).
  - FSM state enum {RUN, STALL, STUCK}.
  - Default RESET_PC.
- One sub-module, sat_counter (CNT_W wide, inc, rst), instantiated twice for stall_count and flush_count.
- PC register, IF/ID register and FSM stay in if_id_stage.

Test Plan:
1. Reset then free run: rst 2 cycles, pc_next=pc_plus4, instr_in=pc-derived. Expect pc 0,4,8,...; if_id_pc4 trails by 1 cycle; valid=1 from the 2nd edge.
2. Single load-use stall: pc_write=awrite=0 for 1 cycle at pc=8. Expect pc=8 for 2 cycles, IF/ID held; stall_count=1; FSM RUN->STALL->RUN; no errors.
3. Flush during stall: awrite=0, pc_write=1, flush=1, pc_next=0x40. Expect pc=0x40, if_id_instr=0, valid=0; flush_count=1; stall_count unchanged.
4. Watchdog: hold awrite=pc_write=0 for 4 cycles (MAX_STALL=4). Expect stall_err=1 after the 4th edge; it stays 1 after stalls end until rst.
5. Mismatch and saturation: pc_write=1, awrite=0 for 1 cycle gives mismatch_err=1. With CNT_W=4, 20 flush cycles leave flush_count=15.
6. Wrap and mid-stall reset: pc=0xFFFF_FFFC gives pc_plus4=0. rst during STALL gives pc=RESET_PC and FSM=RUN on the next edge.
